// File: rtl/elink_lite_if.sv
// rtl/elink_lite_if.sv - elink_lite port bundle: host fabric channels, link pins, mailbox
interface elink_lite_if;
    logic [2:0]   clkbypass;
    logic [3:0]   rowid;
    logic [3:0]   colid;
    logic         chip_resetb;
    logic         cclk_p, cclk_n;
    logic         txo_lclk_p, txo_lclk_n;
    logic [7:0]   txo_data_p, txo_data_n;
    logic         txo_frame_p, txo_frame_n;
    logic         txi_wr_wait_p, txi_wr_wait_n, txi_rd_wait_p, txi_rd_wait_n;
    logic         rxi_lclk_p, rxi_lclk_n;
    logic [7:0]   rxi_data_p, rxi_data_n;
    logic         rxi_frame_p, rxi_frame_n;
    logic         rxo_wr_wait_p, rxo_wr_wait_n, rxo_rd_wait_p, rxo_rd_wait_n;
    logic         txwr_access, txrd_access, txrr_access;
    logic [103:0] txwr_packet, txrd_packet, txrr_packet;
    logic         txwr_wait, txrd_wait, txrr_wait;
    logic         rxwr_access, rxrd_access, rxrr_access;
    logic [103:0] rxwr_packet, rxrd_packet, rxrr_packet;
    logic         rxwr_wait, rxrd_wait, rxrr_wait;
    logic         mailbox_pop;
    logic [63:0]  mailbox_data;
    logic         mailbox_full, mailbox_not_empty;

    modport slave (
        input  clkbypass,
        output rowid, colid, chip_resetb, cclk_p, cclk_n, txo_lclk_p, txo_lclk_n,
        output txo_data_p, txo_data_n, txo_frame_p, txo_frame_n,
        input  txi_wr_wait_p, txi_wr_wait_n, txi_rd_wait_p, txi_rd_wait_n,
        input  rxi_lclk_p, rxi_lclk_n, rxi_data_p, rxi_data_n, rxi_frame_p, rxi_frame_n,
        output rxo_wr_wait_p, rxo_wr_wait_n, rxo_rd_wait_p, rxo_rd_wait_n,
        input  txwr_access, txrd_access, txrr_access,
        input  txwr_packet, txrd_packet, txrr_packet,
        output txwr_wait, txrd_wait, txrr_wait,
        output rxwr_access, rxrd_access, rxrr_access,
        output rxwr_packet, rxrd_packet, rxrr_packet,
        input  rxwr_wait, rxrd_wait, rxrr_wait,
        input  mailbox_pop,
        output mailbox_data, mailbox_full, mailbox_not_empty
    );

    modport master (
        output clkbypass,
        input  rowid, colid, chip_resetb, cclk_p, cclk_n, txo_lclk_p, txo_lclk_n,
        input  txo_data_p, txo_data_n, txo_frame_p, txo_frame_n,
        output txi_wr_wait_p, txi_wr_wait_n, txi_rd_wait_p, txi_rd_wait_n,
        output rxi_lclk_p, rxi_lclk_n, rxi_data_p, rxi_data_n, rxi_frame_p, rxi_frame_n,
        input  rxo_wr_wait_p, rxo_wr_wait_n, rxo_rd_wait_p, rxo_rd_wait_n,
        output txwr_access, txrd_access, txrr_access,
        output txwr_packet, txrd_packet, txrr_packet,
        input  txwr_wait, txrd_wait, txrr_wait,
        input  rxwr_access, rxrd_access, rxrr_access,
        input  rxwr_packet, rxrd_packet, rxrr_packet,
        output rxwr_wait, rxrd_wait, rxrr_wait,
        output mailbox_pop,
        input  mailbox_data, mailbox_full, mailbox_not_empty
    );
endinterface

// File: rtl/elink_lite.sv
// rtl/elink_lite.sv - single-clock eLink endpoint: TX arbiter/serializer, RX deserializer/router, mailbox
module elink_lite #(
    parameter logic [11:0] ID         = 12'h810,
    parameter logic [19:0] MBOX_ADDR  = 20'hF0368,
    parameter int          MBOX_DEPTH = 4
) (
    input  logic        clkin,
    input  logic        hard_reset,
    elink_lite_if.slave bus
);
    localparam int CH_WR = 0;
    localparam int CH_RD = 1;
    localparam int CH_RR = 2;
    localparam int MB_AW = $clog2(MBOX_DEPTH);
    localparam logic [MB_AW:0] MB_FULL_CNT = (MB_AW + 1)'(MBOX_DEPTH);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic               chip_resetb_q;
    logic [2:0]         tx_acc;
    logic [103:0]       tx_in [3];
    logic [2:0]         txb_full_q;
    logic [103:0]       txb_pkt_q [3];
    logic [2:0]         gnt_oh;
    logic [103:0]       gnt_pkt;
    logic [0:0]         tx_state_q;
    logic [3:0]         tx_cnt_q;
    logic [95:0]        tx_sh_q;
    logic [7:0]         txo_data_q;
    logic               txo_frame_q;
    logic [3:0]         rx_cnt_q;
    logic               rx_done_q;
    logic [95:0]        rx_sh_q;
    logic               rx_take, rx_last;
    logic [103:0]       rx_pkt;
    logic [31:0]        rx_dst;
    logic [2:0]         route_oh;
    logic               mb_hit;
    logic [2:0]         rx_wait;
    logic [2:0]         rxo_acc_q;
    logic [103:0]       rxo_pkt_q [3];
    logic [63:0]        mb_mem_q [MBOX_DEPTH];
    logic [MB_AW-1:0]   mb_wr_q, mb_rd_q;
    logic [MB_AW:0]     mb_count_q, mb_count_d;
    logic               mb_full_q, mb_ne_q;
    logic               mb_push, mb_pop;
    logic               unused_inputs;

    assign tx_acc       = {bus.txrr_access, bus.txrd_access, bus.txwr_access};
    assign tx_in[CH_WR] = bus.txwr_packet;
    assign tx_in[CH_RD] = bus.txrd_packet;
    assign tx_in[CH_RR] = bus.txrr_packet;
    assign rx_wait      = {bus.rxrr_wait, bus.rxrd_wait, bus.rxwr_wait};

    // Chip reset releases on the first clock edge after hard_reset drops
    always_ff @(posedge clkin or posedge hard_reset) begin
        if (hard_reset) chip_resetb_q <= 1'b0;
        else            chip_resetb_q <= 1'b1;
    end

    // Per-channel TX buffers: capture when empty, release at the grant edge
    always_ff @(posedge clkin or posedge hard_reset) begin
        if (hard_reset) begin
            txb_full_q <= '0;
            for (int i = 0; i < 3; i++) txb_pkt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (gnt_oh[i]) begin
                    txb_full_q[i] <= 1'b0;
                end else if (tx_acc[i] && !txb_full_q[i]) begin
                    txb_full_q[i] <= 1'b1;
                    txb_pkt_q[i]  <= tx_in[i];
                end
            end
        end
    end

    // Fixed-priority grant rr > rd > wr, gated by the remote stall for each path
    always_comb begin
        gnt_oh = 3'b000;
        if (tx_state_q == S_IDLE) begin
            if (txb_full_q[CH_RR] && !bus.txi_wr_wait_p)      gnt_oh[CH_RR] = 1'b1;
            else if (txb_full_q[CH_RD] && !bus.txi_rd_wait_p) gnt_oh[CH_RD] = 1'b1;
            else if (txb_full_q[CH_WR] && !bus.txi_wr_wait_p) gnt_oh[CH_WR] = 1'b1;
        end
    end

    assign gnt_pkt = gnt_oh[CH_RR] ? txb_pkt_q[CH_RR] :
                     gnt_oh[CH_RD] ? txb_pkt_q[CH_RD] : txb_pkt_q[CH_WR];

    // Serializer: byte 0 goes out with the grant, 12 more follow, then frame drops
    always_ff @(posedge clkin or posedge hard_reset) begin
        if (hard_reset) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= 4'd0;
            tx_sh_q     <= '0;
            txo_data_q  <= 8'h00;
            txo_frame_q <= 1'b0;
        end else if (tx_state_q == S_IDLE) begin
            if (|gnt_oh) begin
                tx_state_q  <= S_SEND;
                tx_cnt_q    <= 4'd0;
                tx_sh_q     <= gnt_pkt[95:0];
                txo_data_q  <= gnt_pkt[103:96];
                txo_frame_q <= 1'b1;
            end
        end else if (tx_cnt_q == 4'd12) begin
            tx_state_q  <= S_IDLE;
            txo_data_q  <= 8'h00;
            txo_frame_q <= 1'b0;
        end else begin
            tx_cnt_q    <= tx_cnt_q + 4'd1;
            txo_data_q  <= tx_sh_q[95:88];
            tx_sh_q     <= {tx_sh_q[87:0], 8'h00};
        end
    end

    assign rx_take = bus.rxi_frame_p && !rx_done_q;
    assign rx_last = rx_take && (rx_cnt_q == 4'd12);
    assign rx_pkt  = {rx_sh_q, bus.rxi_data_p};
    assign rx_dst  = rx_pkt[39:8];

    // Deserializer: first 13 bytes of a frame form a packet; a short frame is discarded
    always_ff @(posedge clkin or posedge hard_reset) begin
        if (hard_reset) begin
            rx_cnt_q  <= 4'd0;
            rx_done_q <= 1'b0;
            rx_sh_q   <= '0;
        end else if (!bus.rxi_frame_p) begin
            rx_cnt_q  <= 4'd0;
            rx_done_q <= 1'b0;
        end else if (rx_take) begin
            rx_sh_q <= {rx_sh_q[87:0], bus.rxi_data_p};
            if (rx_last) begin
                rx_done_q <= 1'b1;
                rx_cnt_q  <= 4'd0;
            end else begin
                rx_cnt_q  <= rx_cnt_q + 4'd1;
            end
        end
    end

    // Route a completed packet by write bit and destination address
    always_comb begin
        route_oh = 3'b000;
        mb_hit   = 1'b0;
        if (!rx_pkt[0])                     route_oh[CH_RD] = 1'b1;
        else if (rx_dst == {ID, MBOX_ADDR}) mb_hit          = 1'b1;
        else if (rx_dst[31:20] == ID)       route_oh[CH_RR] = 1'b1;
        else                                route_oh[CH_WR] = 1'b1;
    end

    // Output slots hold while the consumer stalls; a pending slot drops new arrivals
    always_ff @(posedge clkin or posedge hard_reset) begin
        if (hard_reset) begin
            rxo_acc_q <= '0;
            for (int i = 0; i < 3; i++) rxo_pkt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (rxo_acc_q[i]) begin
                    if (!rx_wait[i]) rxo_acc_q[i] <= 1'b0;
                end else if (rx_last && route_oh[i]) begin
                    rxo_acc_q[i] <= 1'b1;
                    rxo_pkt_q[i] <= rx_pkt;
                end
            end
        end
    end

    assign mb_push = rx_last && mb_hit && !mb_full_q;
    assign mb_pop  = bus.mailbox_pop && mb_ne_q;

    // Occupancy after this edge's push/pop, used to register the status flags
    always_comb begin
        mb_count_d = mb_count_q;
        if (mb_push && !mb_pop)      mb_count_d = mb_count_q + (MB_AW + 1)'(1);
        else if (!mb_push && mb_pop) mb_count_d = mb_count_q - (MB_AW + 1)'(1);
    end

    // Mailbox FIFO of {srcaddr, data}
    always_ff @(posedge clkin or posedge hard_reset) begin
        if (hard_reset) begin
            for (int i = 0; i < MBOX_DEPTH; i++) mb_mem_q[i] <= '0;
            mb_wr_q    <= '0;
            mb_rd_q    <= '0;
            mb_count_q <= '0;
            mb_full_q  <= 1'b0;
            mb_ne_q    <= 1'b0;
        end else begin
            if (mb_push) begin
                mb_mem_q[mb_wr_q] <= {rx_pkt[103:72], rx_pkt[71:40]};
                mb_wr_q           <= mb_wr_q + MB_AW'(1);
            end
            if (mb_pop) mb_rd_q <= mb_rd_q + MB_AW'(1);
            mb_count_q <= mb_count_d;
            mb_full_q  <= (mb_count_d == MB_FULL_CNT);
            mb_ne_q    <= (mb_count_d != '0);
        end
    end

    assign bus.rowid             = ID[11:8];
    assign bus.colid             = ID[3:0];
    assign bus.chip_resetb       = chip_resetb_q;
    assign bus.cclk_p            = bus.clkbypass[0] ? 1'b0 : clkin;
    assign bus.cclk_n            = bus.clkbypass[0] ? 1'b1 : ~clkin;
    assign bus.txo_lclk_p        = clkin;
    assign bus.txo_lclk_n        = ~clkin;
    assign bus.txo_data_p        = txo_data_q;
    assign bus.txo_data_n        = ~txo_data_q;
    assign bus.txo_frame_p       = txo_frame_q;
    assign bus.txo_frame_n       = ~txo_frame_q;
    assign bus.rxo_wr_wait_p     = rxo_acc_q[CH_WR] | rxo_acc_q[CH_RR] | mb_full_q;
    assign bus.rxo_wr_wait_n     = ~bus.rxo_wr_wait_p;
    assign bus.rxo_rd_wait_p     = rxo_acc_q[CH_RD];
    assign bus.rxo_rd_wait_n     = ~rxo_acc_q[CH_RD];
    assign bus.txwr_wait         = txb_full_q[CH_WR];
    assign bus.txrd_wait         = txb_full_q[CH_RD];
    assign bus.txrr_wait         = txb_full_q[CH_RR];
    assign bus.rxwr_access       = rxo_acc_q[CH_WR];
    assign bus.rxrd_access       = rxo_acc_q[CH_RD];
    assign bus.rxrr_access       = rxo_acc_q[CH_RR];
    assign bus.rxwr_packet       = rxo_pkt_q[CH_WR];
    assign bus.rxrd_packet       = rxo_pkt_q[CH_RD];
    assign bus.rxrr_packet       = rxo_pkt_q[CH_RR];
    assign bus.mailbox_data      = mb_ne_q ? mb_mem_q[mb_rd_q] : 64'h0;
    assign bus.mailbox_full      = mb_full_q;
    assign bus.mailbox_not_empty = mb_ne_q;

    // Single-clock, single-ended receiver: these pins carry nothing we need
    assign unused_inputs = ^{bus.clkbypass[2:1], bus.txi_wr_wait_n, bus.txi_rd_wait_n,
                             bus.rxi_lclk_p, bus.rxi_lclk_n, bus.rxi_data_n, bus.rxi_frame_n};
endmodule

// File: tb/tb_elink_lite.sv
// tb/tb_elink_lite.sv - scoreboard bench for elink_lite with txo->rxi loopback
module tb_elink_lite;
    logic clkin;
    logic hard_reset;
    logic lb_en;
    logic [7:0] rxd_drv;
    logic rxf_drv;
    int n_checks = 0;
    int n_fail = 0;

    logic [103:0] exp_tx[$];
    logic [103:0] exp_rx[$];
    logic [63:0]  exp_mb[$];

    elink_lite_if bus ();

    elink_lite dut (
        .clkin      (clkin),
        .hard_reset (hard_reset),
        .bus        (bus)
    );

    assign bus.rxi_data_p  = lb_en ? bus.txo_data_p  : rxd_drv;
    assign bus.rxi_frame_p = lb_en ? bus.txo_frame_p : rxf_drv;
    assign bus.rxi_data_n  = ~bus.rxi_data_p;
    assign bus.rxi_frame_n = ~bus.rxi_frame_p;

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    initial begin
        #500000;
        $display("FAIL global_timeout: run did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [103:0] mk(input logic [31:0] src, input logic [31:0] data,
                                        input logic [31:0] dst, input logic wr);
        return {src, data, dst, 1'b0, 4'h0, 2'b00, wr};
    endfunction

    task automatic send_tx(input int ch, input logic [103:0] pkt);
        case (ch)
            0: begin bus.txwr_packet = pkt; bus.txwr_access = 1'b1; end
            1: begin bus.txrd_packet = pkt; bus.txrd_access = 1'b1; end
            default: begin bus.txrr_packet = pkt; bus.txrr_access = 1'b1; end
        endcase
        @(negedge clkin);
        bus.txwr_access = 1'b0;
        bus.txrd_access = 1'b0;
        bus.txrr_access = 1'b0;
    endtask

    task automatic get_frame(output logic [103:0] pkt, output int nbytes);
        int guard = 0;
        pkt = '0;
        nbytes = 0;
        while (bus.txo_frame_p !== 1'b1 && guard < 200) begin
            @(negedge clkin);
            guard++;
        end
        while (bus.txo_frame_p === 1'b1 && nbytes < 20) begin
            pkt = {pkt[95:0], bus.txo_data_p};
            nbytes++;
            @(negedge clkin);
        end
    endtask

    task automatic wait_rx(input int ch, output logic [103:0] pkt, output bit seen);
        seen = 1'b0;
        pkt = '0;
        for (int n = 0; n < 200 && !seen; n++) begin
            case (ch)
                0: if (bus.rxwr_access === 1'b1) begin seen = 1'b1; pkt = bus.rxwr_packet; end
                1: if (bus.rxrd_access === 1'b1) begin seen = 1'b1; pkt = bus.rxrd_packet; end
                default: if (bus.rxrr_access === 1'b1) begin seen = 1'b1; pkt = bus.rxrr_packet; end
            endcase
            if (!seen) @(negedge clkin);
        end
    endtask

    task automatic test_reset();
        hard_reset = 1'b1;
        repeat (3) @(negedge clkin);
        n_checks++;
        if ({bus.txo_frame_p, bus.txo_frame_n, bus.txo_data_n} !== {1'b0, 1'b1, 8'hFF}) begin
            n_fail++;
            $display("FAIL reset_tx_pins: got %h want %h", {bus.txo_frame_p, bus.txo_frame_n, bus.txo_data_n}, 10'h1FF);
        end
        n_checks++;
        if ({bus.chip_resetb, bus.rxwr_access, bus.rxrd_access, bus.rxrr_access, bus.mailbox_not_empty} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000", {bus.chip_resetb, bus.rxwr_access, bus.rxrd_access, bus.rxrr_access, bus.mailbox_not_empty});
        end
        n_checks++;
        if ({bus.rxo_wr_wait_n, bus.rxo_rd_wait_n, bus.txwr_wait, bus.rowid, bus.colid} !== {2'b11, 1'b0, 4'h8, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_misc: got %h want %h", {bus.rxo_wr_wait_n, bus.rxo_rd_wait_n, bus.txwr_wait, bus.rowid, bus.colid}, {2'b11, 1'b0, 4'h8, 4'h0});
        end
        hard_reset = 1'b0;
        #1;
        n_checks++;
        if (bus.chip_resetb !== 1'b0) begin
            n_fail++;
            $display("FAIL chip_resetb_release_early: got %b want 0", bus.chip_resetb);
        end
        @(negedge clkin);
        n_checks++;
        if (bus.chip_resetb !== 1'b1) begin
            n_fail++;
            $display("FAIL chip_resetb_release: got %b want 1", bus.chip_resetb);
        end
        @(posedge clkin);
        #1;
        bus.clkbypass = 3'b001;
        #1;
        n_checks++;
        if ({bus.cclk_p, bus.cclk_n} !== 2'b01) begin
            n_fail++;
            $display("FAIL clkbypass: got %b want 01", {bus.cclk_p, bus.cclk_n});
        end
        bus.clkbypass = 3'b000;
        #1;
        n_checks++;
        if ({bus.cclk_p, bus.cclk_n} !== 2'b10) begin
            n_fail++;
            $display("FAIL cclk_follow: got %b want 10", {bus.cclk_p, bus.cclk_n});
        end
        @(negedge clkin);
    endtask

    task automatic test_tx_single();
        logic [103:0] pkt, got, exp;
        int nb;
        pkt = 104'h0123_4567_89AB_CDEF_0123_4567_CD;
        exp_tx.push_back(pkt);
        send_tx(0, pkt);
        n_checks++;
        if (bus.txwr_wait !== 1'b1) begin
            n_fail++;
            $display("FAIL txwr_wait_after_access: got %b want 1", bus.txwr_wait);
        end
        get_frame(got, nb);
        exp = exp_tx.pop_front();
        n_checks++;
        if (nb !== 13) begin
            n_fail++;
            $display("FAIL tx_frame_len: got %0d want 13", nb);
        end
        n_checks++;
        if ({got[103:96], got[7:0]} !== 16'h01CD) begin
            n_fail++;
            $display("FAIL tx_byte0_byte12: got %h want 01cd", {got[103:96], got[7:0]});
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL tx_packet: got %h want %h", got, exp);
        end
        n_checks++;
        if ({bus.txo_frame_p, bus.txo_data_p} !== 9'h000) begin
            n_fail++;
            $display("FAIL tx_idle_after_frame: got %h want 000", {bus.txo_frame_p, bus.txo_data_p});
        end
        repeat (3) @(negedge clkin);
    endtask

    task automatic test_arbitration();
        logic [103:0] p_wr, p_rd, p_rr, got, exp;
        int nb;
        p_wr = mk(32'h1000_0001, 32'h2000_0001, 32'h8200_0100, 1'b1);
        p_rd = mk(32'h1000_0002, 32'h2000_0002, 32'h8300_0200, 1'b0);
        p_rr = mk(32'h1000_0003, 32'h2000_0003, 32'h8400_0300, 1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            bus.txi_rd_wait_p = (pass == 1);
            exp_tx.push_back(p_rr);
            if (pass == 0) exp_tx.push_back(p_rd);
            exp_tx.push_back(p_wr);
            bus.txwr_packet = p_wr; bus.txrd_packet = p_rd; bus.txrr_packet = p_rr;
            bus.txwr_access = 1'b1; bus.txrd_access = 1'b1; bus.txrr_access = 1'b1;
            @(negedge clkin);
            bus.txwr_access = 1'b0; bus.txrd_access = 1'b0; bus.txrr_access = 1'b0;
            n_checks++;
            if ({bus.txrr_wait, bus.txrd_wait, bus.txwr_wait} !== 3'b111) begin
                n_fail++;
                $display("FAIL arb_all_waits: got %b want 111", {bus.txrr_wait, bus.txrd_wait, bus.txwr_wait});
            end
            for (int k = 0; k < 3 - pass; k++) begin
                get_frame(got, nb);
                exp = exp_tx.pop_front();
                n_checks++;
                if (got !== exp || nb !== 13) begin
                    n_fail++;
                    $display("FAIL arb_order_p%0d_k%0d: got %h len %0d want %h len 13", pass, k, got, nb, exp);
                end
            end
            if (pass == 1) begin
                repeat (3) @(negedge clkin);
                n_checks++;
                if ({bus.txrd_wait, bus.txo_frame_p} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL arb_rd_held: got %b want 10", {bus.txrd_wait, bus.txo_frame_p});
                end
                exp_tx.push_back(p_rd);
                bus.txi_rd_wait_p = 1'b0;
                get_frame(got, nb);
                exp = exp_tx.pop_front();
                n_checks++;
                if (got !== exp || nb !== 13) begin
                    n_fail++;
                    $display("FAIL arb_rd_after_wait: got %h len %0d want %h", got, nb, exp);
                end
            end
            repeat (3) @(negedge clkin);
        end
    endtask

    task automatic test_loopback();
        logic [103:0] pkt, got, exp;
        bit seen;
        int ch;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin pkt = mk(32'hAAAA_0001, 32'h5555_0001, 32'h8100_0000, 1'b1); ch = 2; end
                1: begin pkt = mk(32'hAAAA_0002, 32'h5555_0002, 32'h8200_0000, 1'b1); ch = 0; end
                default: begin pkt = mk(32'hAAAA_0003, 32'h5555_0003, 32'h8200_0040, 1'b0); ch = 1; end
            endcase
            exp_rx.push_back(pkt);
            send_tx(0, pkt);
            wait_rx(ch, got, seen);
            exp = exp_rx.pop_front();
            n_checks++;
            if (!seen || got !== exp) begin
                n_fail++;
                $display("FAIL loopback_ch%0d: seen %b got %h want %h", ch, seen, got, exp);
            end
            @(negedge clkin);
            n_checks++;
            if ({bus.rxwr_access, bus.rxrd_access, bus.rxrr_access} !== 3'b000) begin
                n_fail++;
                $display("FAIL loopback_pulse_ch%0d: got %b want 000", ch, {bus.rxwr_access, bus.rxrd_access, bus.rxrr_access});
            end
            repeat (3) @(negedge clkin);
        end
    endtask

    task automatic test_stall();
        logic [103:0] pa, pb, got, exp;
        bit seen;
        int pulses = 0;
        pa = mk(32'hBEEF_0001, 32'hCAFE_0001, 32'h8200_0000, 1'b1);
        pb = mk(32'hBEEF_0002, 32'hCAFE_0002, 32'h8200_1111, 1'b1);
        bus.rxwr_wait = 1'b1;
        exp_rx.push_back(pa);
        send_tx(0, pa);
        wait_rx(0, got, seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL stall_first_delivery: got none want access");
        end
        send_tx(0, pb);
        repeat (25) @(negedge clkin);
        exp = exp_rx.pop_front();
        n_checks++;
        if ({bus.rxwr_access, bus.rxwr_packet} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL stall_held: got %b %h want 1 %h", bus.rxwr_access, bus.rxwr_packet, exp);
        end
        n_checks++;
        if ({bus.rxo_wr_wait_p, bus.rxo_wr_wait_n} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_rxo_wait: got %b want 10", {bus.rxo_wr_wait_p, bus.rxo_wr_wait_n});
        end
        bus.rxwr_wait = 1'b0;
        @(negedge clkin);
        for (int n = 0; n < 20; n++) begin
            if (bus.rxwr_access === 1'b1) pulses++;
            @(negedge clkin);
        end
        n_checks++;
        if (pulses !== 0 || bus.rxo_wr_wait_p !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release_single: got %0d extra cycles wait %b want 0 extra wait 0", pulses, bus.rxo_wr_wait_p);
        end
    endtask

    task automatic test_mailbox();
        logic [103:0] pkt;
        logic [63:0] exp;
        for (int k = 0; k < 5; k++) begin
            pkt = mk(32'hA000_0000 + k, 32'hD000_0000 + k, 32'h810F_0368, 1'b1);
            if (k < 4) exp_mb.push_back({pkt[103:72], pkt[71:40]});
            send_tx(0, pkt);
            repeat (20) @(negedge clkin);
            n_checks++;
            if ({bus.mailbox_not_empty, bus.mailbox_full} !== {1'b1, (k >= 3) ? 1'b1 : 1'b0}) begin
                n_fail++;
                $display("FAIL mbox_flags_after_%0d: got %b want %b", k + 1, {bus.mailbox_not_empty, bus.mailbox_full}, {1'b1, (k >= 3) ? 1'b1 : 1'b0});
            end
        end
        n_checks++;
        if ({bus.rxo_wr_wait_p, bus.rxwr_access, bus.rxrr_access} !== 3'b100) begin
            n_fail++;
            $display("FAIL mbox_full_wait: got %b want 100", {bus.rxo_wr_wait_p, bus.rxwr_access, bus.rxrr_access});
        end
        for (int k = 0; k < 4; k++) begin
            exp = exp_mb.pop_front();
            n_checks++;
            if (bus.mailbox_data !== exp) begin
                n_fail++;
                $display("FAIL mbox_pop_%0d: got %h want %h", k, bus.mailbox_data, exp);
            end
            bus.mailbox_pop = 1'b1;
            @(negedge clkin);
            bus.mailbox_pop = 1'b0;
        end
        n_checks++;
        if ({bus.mailbox_not_empty, bus.mailbox_full, bus.mailbox_data} !== 66'h0) begin
            n_fail++;
            $display("FAIL mbox_empty: got %h want 0", {bus.mailbox_not_empty, bus.mailbox_full, bus.mailbox_data});
        end
        bus.mailbox_pop = 1'b1;
        @(negedge clkin);
        bus.mailbox_pop = 1'b0;
        n_checks++;
        if ({bus.mailbox_not_empty, bus.mailbox_full} !== 2'b00) begin
            n_fail++;
            $display("FAIL mbox_pop_empty: got %b want 00", {bus.mailbox_not_empty, bus.mailbox_full});
        end
    endtask

    task automatic test_rx_framing();
        logic [103:0] pkt, got, exp;
        logic [103:0] sh;
        bit seen;
        int hits = 0;
        pkt = mk(32'h7777_0001, 32'h6666_0001, 32'h8200_0000, 1'b1);
        lb_en = 1'b0;
        bus.rxwr_wait = 1'b1;
        sh = pkt;
        for (int k = 0; k < 7; k++) begin
            rxf_drv = 1'b1;
            rxd_drv = sh[103:96];
            sh = {sh[95:0], 8'h00};
            @(negedge clkin);
        end
        rxf_drv = 1'b0;
        rxd_drv = 8'h00;
        for (int n = 0; n < 20; n++) begin
            if (bus.rxwr_access === 1'b1) hits++;
            @(negedge clkin);
        end
        n_checks++;
        if (hits !== 0) begin
            n_fail++;
            $display("FAIL rx_cut_frame: got %0d access cycles want 0", hits);
        end
        exp_rx.push_back(pkt);
        sh = pkt;
        for (int k = 0; k < 15; k++) begin
            rxf_drv = 1'b1;
            rxd_drv = (k < 13) ? sh[103:96] : 8'hEE;
            sh = {sh[95:0], 8'h00};
            @(negedge clkin);
        end
        rxf_drv = 1'b0;
        rxd_drv = 8'h00;
        wait_rx(0, got, seen);
        exp = exp_rx.pop_front();
        n_checks++;
        if (!seen || got !== exp) begin
            n_fail++;
            $display("FAIL rx_long_frame: seen %b got %h want %h", seen, got, exp);
        end
        bus.rxwr_wait = 1'b0;
        repeat (2) @(negedge clkin);
        lb_en = 1'b1;
    endtask

    task automatic test_reset_midpacket();
        logic [103:0] pkt;
        int hits = 0;
        pkt = mk(32'h3333_0001, 32'h4444_0001, 32'h8200_0000, 1'b1);
        send_tx(0, pkt);
        repeat (6) @(negedge clkin);
        hard_reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.txo_frame_p, bus.txwr_wait, bus.chip_resetb} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_tx: got %b want 000", {bus.txo_frame_p, bus.txwr_wait, bus.chip_resetb});
        end
        @(negedge clkin);
        hard_reset = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (bus.rxwr_access === 1'b1 || bus.txo_frame_p === 1'b1) hits++;
            @(negedge clkin);
        end
        n_checks++;
        if (hits !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_delivery: got %0d active cycles want 0", hits);
        end
    endtask

    initial begin
        hard_reset = 1'b1;
        lb_en = 1'b1;
        rxd_drv = 8'h00;
        rxf_drv = 1'b0;
        bus.clkbypass = 3'b000;
        bus.txi_wr_wait_p = 1'b0; bus.txi_wr_wait_n = 1'b1;
        bus.txi_rd_wait_p = 1'b0; bus.txi_rd_wait_n = 1'b1;
        bus.rxi_lclk_p = 1'b0; bus.rxi_lclk_n = 1'b1;
        bus.txwr_access = 1'b0; bus.txrd_access = 1'b0; bus.txrr_access = 1'b0;
        bus.txwr_packet = '0; bus.txrd_packet = '0; bus.txrr_packet = '0;
        bus.rxwr_wait = 1'b0; bus.rxrd_wait = 1'b0; bus.rxrr_wait = 1'b0;
        bus.mailbox_pop = 1'b0;
        test_reset();
        test_tx_single();
        test_arbitration();
        test_loopback();
        test_stall();
        test_mailbox();
        test_rx_framing();
        test_reset_midpacket();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/elink_lite.md
Name: elink_lite

Overview:
- Single-clock, simplified Epiphany eLink endpoint.
- TX side: accepts 104-bit emesh packets on three channels (write, read, read-response), arbitrates between them and serializes each packet as 13 bytes on an 8-bit framed link.
- RX side: deserializes framed link bytes into 104-bit packets and routes each packet to the write, read, read-response or mailbox path.
- Sits between the host fabric and the chip-side link pins.

Parameters:
- ID, 12'h810, link ID. rowid = ID[11:8], colid = ID[3:0].
- MBOX_ADDR, 20'hF0368, mailbox offset inside this ID's address space.
- MBOX_DEPTH, 4, mailbox FIFO entries (power of 2).

Ports:
- clkin  in  1  clock
- hard_reset  in  1  asynchronous reset, active-high
- clkbypass  in  3  bit0=1 forces cclk_p/cclk_n to 0/1; bits 2:1 unused
- rowid, colid  out  4 each  constants from ID
- chip_resetb  out  1  chip reset, active-low
- cclk_p, cclk_n  out  1 each  chip clock = clkin / ~clkin
- txo_lclk_p, txo_lclk_n  out  1 each  = clkin / ~clkin
- txo_data_p, txo_data_n  out  8 each  link byte / its complement
- txo_frame_p, txo_frame_n  out  1 each  frame / its complement
- txi_wr_wait_p, txi_wr_wait_n, txi_rd_wait_p, txi_rd_wait_n  in  1 each  remote stalls; only _p used
- rxi_lclk_p, rxi_lclk_n  in  1 each  ignored (single clock)
- rxi_data_p, rxi_data_n  in  8 each  only _p used
- rxi_frame_p, rxi_frame_n  in  1 each  only _p used
- rxo_wr_wait_p, rxo_wr_wait_n, rxo_rd_wait_p, rxo_rd_wait_n  out  1 each  RX back-pressure and complements
- txwr_access, txrd_access, txrr_access  in  1 each  TX request
- txwr_packet, txrd_packet, txrr_packet  in  104 each  TX packet
- txwr_wait, txrd_wait, txrr_wait  out  1 each  TX buffer full
- rxwr_access, rxrd_access, rxrr_access  out  1 each  RX valid
- rxwr_packet, rxrd_packet, rxrr_packet  out  104 each  RX packet
- rxwr_wait, rxrd_wait, rxrr_wait  in  1 each  consumer stall
- mailbox_pop  in  1  dequeue mailbox head
- mailbox_data  out  64  head entry, {srcaddr, data}
- mailbox_full, mailbox_not_empty  out  1 each  FIFO status

Behaviour:
- Packet fields:
  - [0] write
  - [2:1] datamode
  - [6:3] ctrlmode
  - [39:8] dstaddr
  - [71:40] data
  - [103:72] srcaddr
- Reset state (async):
  - All registered outputs are 0, so txo_data_n=8'hFF, txo_frame_n=1, rxo_*_wait_n=1.
  - chip_resetb=0; it rises at the first clkin edge after reset deasserts.
  - FIFO empty, all buffers empty.
  - Reset mid-packet aborts TX and RX with no partial delivery.
- TX buffers (one per channel):
  - txX_wait = buffer occupied.
  - The buffer captures txX_packet at an edge where access=1 and wait=0; access while wait=1 is ignored.
- TX arbiter (serializer idle only):
  - Priority rr > rd > wr.
  - rr and wr are eligible only if txi_wr_wait_p=0; rd only if txi_rd_wait_p=0.
  - The granted buffer empties at the grant edge.
- Serializer:
  - Starting the edge after the grant, drives 13 consecutive cycles with txo_frame_p=1.
  - Byte k (k=0..12) is packet[103-8k -: 8], MSB-first.
  - Then at least 1 idle cycle with frame=0 and data=0.
  - Remote waits do not interrupt a packet in flight.
- Deserializer:
  - Samples rxi_data_p on each cycle where rxi_frame_p=1, counting from the first cycle of frame=1.
  - After byte 12 the packet is complete; further bytes in the same frame are ignored until frame=0.
  - Frame falling before 13 bytes discards the packet.
  - If the output slot is still pending when byte 12 arrives, the new packet is dropped (the sender must honour rxo waits).
- Routing of a complete packet:
  - write=0 -> rd.
  - write=1 and dstaddr == {ID, MBOX_ADDR} -> mailbox.
  - write=1 and dstaddr[31:20]==ID -> rr.
  - Otherwise -> wr.
- Routed output:
  - rxX_access and rxX_packet assert the edge after byte 12 and stay stable while rxX_wait=1.
  - They drop one cycle after an edge with wait=0, so an unstalled access is a 1-cycle pulse.
- RX back-pressure:
  - rxo_wr_wait_p = wr or rr output pending, or mailbox_full.
  - rxo_rd_wait_p = rd output pending.
- Mailbox:
  - Pushes {srcaddr, data} when routed.
  - Push when full: dropped. Pop when empty: ignored. Simultaneous push and pop allowed.
  - mailbox_data shows the head (0 when empty).
  - Status flags are registered, updated the edge of the push/pop.

Test Plan:
- Reset: hard_reset=1 -> txo_frame_p=0, txo_frame_n=1, chip_resetb=0, all access=0. Release -> chip_resetb=1 after one edge.
- TX single write: txwr_access with packet 104'h0123…CD -> txwr_wait=1 next cycle; frame high 13 cycles; byte0=packet[103:96], byte12=packet[7:0].
- Arbitration: rr, rd, wr all requested the same cycle -> send order rr, rd, wr. With txi_rd_wait_p=1 -> order rr, wr, then rd after the wait drops.
- Loopback txo->rxi:
  - write to dstaddr 32'h8100_0000 -> rxrr_access pulse with identical packet.
  - write to 32'h8200_0000 -> rxwr.
  - write=0 -> rxrd.
- Stall: rxwr_wait=1 -> rxwr_access held, rxo_wr_wait_p=1, next incoming write dropped; release -> single delivery.
- Mailbox: 5 writes to {ID, MBOX_ADDR} -> mailbox_full after 4, 5th dropped; pop 4x -> data in order, mailbox_not_empty=0. A frame cut at 7 bytes -> no delivery.
